ram_march_bist: RTL and testbench
=================================

RAM_MARCH_BIST -- requirements
Module: ram_march_bist

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- ADDR_WIDTH, 16, RAM address width.
- DATA_WIDTH, 32, RAM word width.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on rising edge.
- rst, in, 1, synchronous, active-high reset.
- start, in, 1, request a test run; sampled only in IDLE.
- seed, in, DATA_WIDTH, background pattern P; latched when start is accepted.
- last_addr, in, ADDR_WIDTH, highest address tested; latched when start is accepted; N = last_addr+1.
- busy, out, 1, test in progress.
- done, out, 1, one-cycle completion pulse.
- pass, out, 1, last completed run had zero mismatches.
- fail_cnt, out, 16, saturating mismatch count.
- fail_addr, out, ADDR_WIDTH, address of first mismatch.
- fail_data, out, DATA_WIDTH, read data at first mismatch.
- mem_we, out, 1, RAM write enable.
- mem_addr, out, ADDR_WIDTH, RAM address.
- mem_din, out, DATA_WIDTH, RAM write data.
- mem_dout, in, DATA_WIDTH, RAM read data; combinational function of mem_addr.

Function
REQ-003 The FSM SHALL have states IDLE, M0, M1, M2, M3 and DONE.
- M0: ascending, write P.
- M1: ascending, read expecting P, write ~P.
- M2: descending, read expecting ~P, write P.
- M3: ascending, read expecting P.
REQ-004 In IDLE with start=1, the block SHALL latch seed and last_addr, clear fail_cnt, fail_addr and fail_data, and enter M0 with mem_addr=0.
REQ-005 Each march element SHALL visit one address per cycle.
- Ascending elements run 0..last_addr.
- M2 runs last_addr..0.
- At the end of an element, the FSM moves to the next element at its start address with no idle cycle.
REQ-006 In M1 and M2, the read compare and the write SHALL target the same address in the same cycle. mem_dout is compared before the write edge, and mem_we=1 in that cycle.
REQ-007 mem_we SHALL be 1 only in M0, M1 and M2. mem_din SHALL be P in M0 and M2, ~P in M1, and 0 otherwise.
REQ-008 A mismatch SHALL be mem_dout != expected in M1, M2 or M3.
- Each mismatch increments fail_cnt, saturating at 65535.
- The first mismatch of a run captures fail_addr=mem_addr and fail_data=mem_dout.
REQ-009 busy SHALL be 1 for exactly 4N consecutive cycles, starting the cycle after start is accepted.
REQ-010 After the last M3 read, the FSM SHALL enter DONE for one cycle (done=1, busy=0) and then return to IDLE.
- pass = (fail_cnt==0) is updated at DONE.
- pass, fail_cnt, fail_addr and fail_data are held until the next accepted start.
REQ-011 start asserted outside IDLE SHALL be ignored. It is not queued. Changes to seed and last_addr during a run SHALL have no effect.
REQ-012 last_addr=0 SHALL give N=1: one cycle per element and 4 busy cycles.
REQ-013 last_addr = 2^ADDR_WIDTH-1 SHALL test the full space. Address counters SHALL NOT wrap past the element bounds.

Reset
REQ-014 rst=1 at a clock edge SHALL force IDLE and set these outputs:
- busy=0, done=0, pass=0, fail_cnt=0, fail_addr=0, fail_data=0
- mem_we=0, mem_addr=0, mem_din=0
REQ-015 Reset SHALL take priority over start.
REQ-016 Reset during a run SHALL abort the run with no done pulse. mem_we SHALL be 0 in the cycle following the reset edge.

Configuration
REQ-017 With macro RAM_BIST_FAIL_CAPTURE_EN defined, fail_addr and fail_data SHALL be registered as in REQ-008.
REQ-018 Without RAM_BIST_FAIL_CAPTURE_EN, fail_addr and fail_data SHALL be constant 0 with no capture registers. All other behaviour is unchanged.

Verification
REQ-019 The bench SHALL connect the block to a combinational-read, registered-write single-port RAM model (ADDR_WIDTH=4, DATA_WIDTH=8) and cover these scenarios:
- Clean run: seed=8'hA5, last_addr=15 -> busy for 64 cycles, one done pulse, pass=1, fail_cnt=0.
- Stuck bit: RAM model forces bit 0 of address 5 to 1, seed=8'h00, last_addr=15 -> pass=0, fail_cnt=2 (M1 and M3 reads of address 5), fail_addr=5, fail_data=8'h01 (capture macro defined).
- Minimum size: last_addr=0, seed=8'hFF -> 4 busy cycles, write order P, ~P, P, final memory[0]=8'hFF, pass=1.
- Reset mid-run: rst asserted in the 10th M1 cycle -> mem_we=0 and busy=0 the next cycle, no done pulse, next start runs cleanly.
- Ignored start: start pulsed during M2 -> no restart, total busy count stays 4N.
- Saturation and macro-off: stuck data line on all 16 words with the counter width forced small in the model, or a long run -> fail_cnt holds at 65535; with the macro undefined -> fail_addr=0 and fail_data=0 always.

Source files
------------

// File: rtl/ram_march_bist.sv
// March C- style BIST engine for a single-port RAM with combinational read.
// Latency: busy for 4*(last_addr+1) cycles after start, then a one-cycle done pulse.
// No backpressure: one address per cycle; start is only sampled while idle.
// Optional macro RAM_BIST_FAIL_CAPTURE_EN adds first-failure address/data capture.
module ram_march_bist #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           fail_cnt,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        M3   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pat;
    logic [ADDR_WIDTH-1:0] last_q;

    logic [DATA_WIDTH-1:0] expect_dat;
    logic                  mismatch;
    logic                  first_fail;
    logic [15:0]           cnt_next;
    logic                  at_last;
    logic                  at_zero;
    logic                  start_acc;

    // Read compare against the current element's expected background; saturating count
    always_comb begin
        expect_dat = (state == M2) ? ~pat : pat;
        mismatch   = ((state == M1) || (state == M2) || (state == M3)) && (mem_dout != expect_dat);
        first_fail = mismatch && (fail_cnt == 16'd0);
        cnt_next   = fail_cnt;
        if (mismatch && (fail_cnt != 16'hFFFF)) begin
            cnt_next = fail_cnt + 16'd1;
        end
        at_last   = (mem_addr == last_q);
        at_zero   = (mem_addr == '0);
        start_acc = (state == IDLE) && start;
    end

    // March sequencer: every output is registered and set up one cycle ahead of use
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_cnt <= 16'd0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            pat      <= '0;
            last_q   <= '0;
        end else begin
            done     <= 1'b0;
            fail_cnt <= cnt_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat      <= seed;
                        last_q   <= last_addr;
                        fail_cnt <= 16'd0;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= '0;
                        mem_din  <= seed;
                        state    <= M0;
                    end
                end
                M0: begin
                    if (at_last) begin
                        mem_addr <= '0;
                        mem_din  <= ~pat;
                        state    <= M1;
                    end else begin
                        mem_addr <= mem_addr + ADDR_WIDTH'(1);
                    end
                end
                M1: begin
                    if (at_last) begin
                        mem_addr <= last_q;
                        mem_din  <= pat;
                        state    <= M2;
                    end else begin
                        mem_addr <= mem_addr + ADDR_WIDTH'(1);
                    end
                end
                M2: begin
                    if (at_zero) begin
                        mem_addr <= '0;
                        mem_we   <= 1'b0;
                        mem_din  <= '0;
                        state    <= M3;
                    end else begin
                        mem_addr <= mem_addr - ADDR_WIDTH'(1);
                    end
                end
                M3: begin
                    if (at_last) begin
                        mem_addr <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= (cnt_next == 16'd0);
                        state    <= DONE;
                    end else begin
                        mem_addr <= mem_addr + ADDR_WIDTH'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM_BIST_FAIL_CAPTURE_EN
    // Hold address and read data of the first mismatch of the run
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            fail_addr <= '0;
            fail_data <= '0;
        end else if (first_fail) begin
            fail_addr <= mem_addr;
            fail_data <= mem_dout;
        end
    end
`else
    assign fail_addr = '0;
    assign fail_data = '0;
`endif

endmodule

// File: tb/tb_ram_march_bist.sv
module tb_ram_march_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] seed;
    logic [3:0] last_addr;
    logic       busy, done, pass, mem_we;
    logic [15:0] fail_cnt;
    logic [3:0] fail_addr, mem_addr;
    logic [7:0] fail_data, mem_din, mem_dout;

    // large instance used for counter saturation
    logic        b_start;
    logic [7:0]  b_seed;
    logic [15:0] b_last;
    logic        b_busy, b_done, b_pass, b_mem_we;
    logic [15:0] b_fail_cnt, b_fail_addr, b_mem_addr;
    logic [7:0]  b_fail_data, b_mem_din;
    logic [7:0]  b_mem_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_march_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .last_addr(last_addr),
        .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
        .fail_addr(fail_addr), .fail_data(fail_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    ram_march_bist #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut_big (
        .clk(clk), .rst(rst), .start(b_start), .seed(b_seed), .last_addr(b_last),
        .busy(b_busy), .done(b_done), .pass(b_pass), .fail_cnt(b_fail_cnt),
        .fail_addr(b_fail_addr), .fail_data(b_fail_data),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_dout(b_mem_dout)
    );

    // every data line of the large RAM is stuck, so every read mismatches
    assign b_mem_dout = 8'h5A;

    // small RAM: combinational read with per-address stuck-at-1 bits, registered write
    logic [7:0] ram    [16];
    logic [7:0] stuck1 [16];
    logic [7:0] wr_log [$];

    assign mem_dout = ram[mem_addr] | stuck1[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_din;
            wr_log.push_back(mem_din);
        end
    end

    typedef struct {
        int         busy_cycles;
        logic       pass;
        logic [15:0] cnt;
        logic [3:0] faddr;
        logic [7:0] fdata;
    } exp_t;

    exp_t exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: march elements executed on an array, reads see stuck bits
    function automatic exp_t model(input logic [7:0] p, input int n);
        exp_t e;
        logic [7:0] m [16];
        logic [7:0] r;
        e.cnt   = 16'd0;
        e.faddr = 4'd0;
        e.fdata = 8'd0;
        for (int a = 0; a < n; a++) m[a] = p;
        for (int el = 1; el <= 3; el++) begin
            for (int i = 0; i < n; i++) begin
                int a;
                logic [7:0] want;
                a    = (el == 2) ? (n - 1 - i) : i;
                want = (el == 2) ? ~p : p;
                r    = m[a] | stuck1[a];
                if (r != want) begin
                    if (e.cnt == 16'd0) begin
                        e.faddr = 4'(a);
                        e.fdata = r;
                    end
                    if (e.cnt != 16'hFFFF) e.cnt = e.cnt + 16'd1;
                end
                if (el == 1) m[a] = ~p;
                else if (el == 2) m[a] = p;
            end
        end
`ifndef RAM_BIST_FAIL_CAPTURE_EN
        e.faddr = 4'd0;
        e.fdata = 8'd0;
`endif
        e.pass        = (e.cnt == 16'd0);
        e.busy_cycles = 4 * n;
        return e;
    endfunction

    // Monitor: on each done pulse pop the expected result and compare
    int   busy_run = 0;
    logic prev_done = 1'b0;
    exp_t got_e;
    always @(negedge clk) begin
        if (done) begin
            chk("done_busy_low", busy, 0);
            chk("done_width", prev_done, 0);
            chk("done_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                got_e = exp_q.pop_front();
                chk("busy_cycles", busy_run, got_e.busy_cycles);
                chk("pass", pass, got_e.pass);
                chk("fail_cnt", fail_cnt, got_e.cnt);
                chk("fail_addr", fail_addr, got_e.faddr);
                chk("fail_data", fail_data, got_e.fdata);
            end
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
        prev_done = done;
    end

    // One run: poke >= 0 pulses start mid-run, rst_at >= 0 resets in that busy cycle
    task automatic do_run(input logic [7:0] s, input logic [3:0] la, input int poke, input int rst_at);
        int n;
        bit ended;
        n     = int'(la) + 1;
        ended = 0;
        if (rst_at < 0) exp_q.push_back(model(s, n));
        @(negedge clk);
        seed      = s;
        last_addr = la;
        start     = 1'b1;
        for (int k = 0; k < 4 * n + 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start     = 1'b0;
                seed      = 8'($urandom);
                last_addr = 4'($urandom);
            end
            if (k == poke) begin
                start     = 1'b1;
                seed      = ~s;
                last_addr = 4'($urandom);
            end else if (k == poke + 1) begin
                start = 1'b0;
            end
            if (k == rst_at) begin
                chk("pre_rst_addr", mem_addr, rst_at - n);
                chk("pre_rst_we", mem_we, 1);
                rst = 1'b1;
            end else if (rst_at >= 0 && k == rst_at + 1) begin
                chk("rst_we", mem_we, 0);
                chk("rst_busy", busy, 0);
                rst   = 1'b0;
                ended = 1;
                break;
            end
            if (rst_at < 0 && exp_q.size() == 0) begin
                ended = 1;
                break;
            end
        end
        if (!ended) begin
            chk("run_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        int nf;
        int bbusy;
        bit bgot;
        rst = 1'b1; start = 1'b0; seed = 8'h00; last_addr = 4'd0;
        b_start = 1'b0; b_seed = 8'h00; b_last = 16'd0;
        for (int i = 0; i < 16; i++) stuck1[i] = 8'h00;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_busy0", busy, 0);
        chk("rst_done0", done, 0);
        chk("rst_pass0", pass, 0);
        chk("rst_cnt0", fail_cnt, 0);
        chk("rst_faddr0", fail_addr, 0);
        chk("rst_fdata0", fail_data, 0);
        chk("rst_we0", mem_we, 0);
        chk("rst_addr0", mem_addr, 0);
        chk("rst_din0", mem_din, 0);
        // reset beats start
        start = 1'b1;
        @(negedge clk);
        chk("rst_prio_busy", busy, 0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        // clean run
        do_run(8'hA5, 4'd15, -1, -1);

        // stuck bit 0 at address 5
        stuck1[5] = 8'h01;
        do_run(8'h00, 4'd15, -1, -1);
        stuck1[5] = 8'h00;

        // minimum size
        wr_log.delete();
        do_run(8'hFF, 4'd0, -1, -1);
        chk("min_wr_count", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            chk("min_wr0", wr_log[0], 8'hFF);
            chk("min_wr1", wr_log[1], 8'h00);
            chk("min_wr2", wr_log[2], 8'hFF);
        end
        chk("min_mem0", ram[0], 8'hFF);

        // reset in the 10th M1 cycle, then a clean run
        do_run(8'($urandom), 4'd15, -1, 25);
        do_run(8'($urandom), 4'd15, -1, -1);

        // start pulsed during M2 is ignored
        do_run(8'h3C, 4'd15, 35, -1);

        // randomized runs with random stuck bits
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) stuck1[i] = 8'h00;
            nf = $urandom_range(0, 2);
            for (int f = 0; f < nf; f++)
                stuck1[$urandom_range(0, 15)] |= 8'(1 << $urandom_range(0, 7));
            do_run(8'($urandom), 4'($urandom_range(0, 15)), -1, -1);
        end
        for (int i = 0; i < 16; i++) stuck1[i] = 8'h00;

        // saturation: 3 mismatches per address over 21850 addresses
        @(negedge clk);
        b_seed  = 8'h00;
        b_last  = 16'd21849;
        b_start = 1'b1;
        bbusy   = 0;
        bgot    = 0;
        for (int k = 0; k < 4 * 21850 + 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                b_start = 1'b0;
                b_seed  = 8'($urandom);
                b_last  = 16'($urandom);
            end
            if (b_done) begin
                bgot = 1;
                break;
            end
            if (b_busy) bbusy++;
        end
        chk("sat_done_seen", bgot, 1);
        chk("sat_busy_cycles", bbusy, 4 * 21850);
        chk("sat_pass", b_pass, 0);
        chk("sat_cnt", b_fail_cnt, 16'hFFFF);
`ifdef RAM_BIST_FAIL_CAPTURE_EN
        chk("sat_faddr", b_fail_addr, 0);
        chk("sat_fdata", b_fail_data, 8'h5A);
`else
        chk("sat_faddr", b_fail_addr, 0);
        chk("sat_fdata", b_fail_data, 0);
`endif
        @(negedge clk);
        chk("sat_we_idle", b_mem_we, 0);
        chk("sat_din_idle", b_mem_din, 0);
        chk("sat_addr_idle", b_mem_addr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
